mac_accumulator: RTL and testbench

- Downstream consumer of the 16x16 signed radix-4 Booth multiplier.
- Takes a stream of signed 32-bit products over a valid/ready handshake and accumulates them into a wide saturating accumulator.
- Emits one dot-product result per "last"-tagged product, or when a length limit is reached.
- Sits between the combinational multiplier and the result writeback/consumer logic.

---
 rtl/mac_accumulator.sv | 104 ++++++++++
 tb/tb_mac_accumulator.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_accumulator.sv
// Saturating multiply-accumulate stage: sums a stream of signed 32-bit products and
// emits one result per in_last-tagged product or when MAX_LEN products have been summed.
module mac_accumulator #(
  parameter int ACC_W   = 40,
  parameter int MAX_LEN = 256,
  parameter int CNT_W   = 9
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             product,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_W-1:0]        out_sum,
  output logic [CNT_W-1:0]        out_count,
  output logic                    out_overflow,
  output logic                    out_forced
);

  // Handshake: a product moves when in_valid && in_ready; a result moves when
  // out_valid && out_ready. in_ready depends only on state and out_ready.
  typedef enum logic {ACCUM, HOLD} state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] LEN_LIM = CNT_W'(MAX_LEN);

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               sticky;

  logic               accept;
  logic               transfer;
  logic               close;
  logic               ovf;
  logic [ACC_W-1:0]   base_acc;
  logic [CNT_W-1:0]   base_cnt;
  logic               base_sticky;
  logic [ACC_W:0]     sum;
  logic [ACC_W-1:0]   acc_next;
  logic [CNT_W-1:0]   cnt_inc;

  assign in_ready  = (state == ACCUM) || out_ready;
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign transfer  = out_valid && out_ready;

  // clear takes effect before the product of the same cycle is added.
  always_comb begin
    base_acc    = clear ? '0 : acc;
    base_cnt    = clear ? '0 : cnt;
    base_sticky = clear ? 1'b0 : sticky;
    sum         = {base_acc[ACC_W-1], base_acc} + {{(ACC_W+1-32){product[31]}}, product};
    ovf         = sum[ACC_W] != sum[ACC_W-1];
    if (!ovf)
      acc_next = sum[ACC_W-1:0];
    else if (sum[ACC_W])
      acc_next = ACC_MIN;
    else
      acc_next = ACC_MAX;
    cnt_inc = base_cnt + CNT_W'(1);
    close   = accept && (in_last || cnt_inc == LEN_LIM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ACCUM;
      acc          <= '0;
      cnt          <= '0;
      sticky       <= 1'b0;
      out_sum      <= '0;
      out_count    <= '0;
      out_overflow <= 1'b0;
      out_forced   <= 1'b0;
    end else if (close) begin
      // A close during a transfer reloads the result with no bubble.
      state        <= HOLD;
      out_sum      <= acc_next;
      out_count    <= cnt_inc;
      out_overflow <= base_sticky | ovf;
      out_forced   <= !in_last;
      acc          <= '0;
      cnt          <= '0;
      sticky       <= 1'b0;
    end else begin
      if (accept) begin
        acc    <= acc_next;
        cnt    <= cnt_inc;
        sticky <= base_sticky | ovf;
      end else if (clear) begin
        acc    <= '0;
        cnt    <= '0;
        sticky <= 1'b0;
      end
      if (transfer)
        state <= ACCUM;
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: three instances (default, narrow accumulator, short length)
// driven one at a time; results checked by a queue-based scoreboard against an arithmetic model.
module tb_mac_accumulator;

  localparam int W = 84;  // {inst[2], sum[64], count[16], overflow, forced}

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [31:0] product = '0;
  logic        out_ready = 1'b0;
  logic        rdy_rand = 1'b0;
  logic        rdy_set = 1'b1;
  int          sel = 0;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  int     m_w[3]   = '{40, 34, 40};
  int     m_len[3] = '{256, 256, 4};
  longint m_acc[3] = '{0, 0, 0};
  int     m_cnt[3] = '{0, 0, 0};
  bit     m_sticky[3] = '{0, 0, 0};

  logic iv0, iv1, iv2, cl0, cl1, cl2, or0, or1, or2;
  logic ir0, ir1, ir2, ov0, ov1, ov2, of0, of1, of2, fo0, fo1, fo2;
  logic [39:0] s0, s2;
  logic [33:0] s1;
  logic [8:0]  c0, c1;
  logic [2:0]  c2;

  assign iv0 = in_valid && (sel == 0);
  assign iv1 = in_valid && (sel == 1);
  assign iv2 = in_valid && (sel == 2);
  assign cl0 = clear && (sel == 0);
  assign cl1 = clear && (sel == 1);
  assign cl2 = clear && (sel == 2);
  assign or0 = out_ready && (sel == 0);
  assign or1 = out_ready && (sel == 1);
  assign or2 = out_ready && (sel == 2);

  mac_accumulator u0 (
    .clk(clk), .rst_n(rst_n), .clear(cl0), .in_valid(iv0), .in_ready(ir0),
    .product(product), .in_last(in_last), .out_valid(ov0), .out_ready(or0),
    .out_sum(s0), .out_count(c0), .out_overflow(of0), .out_forced(fo0)
  );

  mac_accumulator #(.ACC_W(34), .MAX_LEN(256), .CNT_W(9)) u1 (
    .clk(clk), .rst_n(rst_n), .clear(cl1), .in_valid(iv1), .in_ready(ir1),
    .product(product), .in_last(in_last), .out_valid(ov1), .out_ready(or1),
    .out_sum(s1), .out_count(c1), .out_overflow(of1), .out_forced(fo1)
  );

  mac_accumulator #(.ACC_W(40), .MAX_LEN(4), .CNT_W(3)) u2 (
    .clk(clk), .rst_n(rst_n), .clear(cl2), .in_valid(iv2), .in_ready(ir2),
    .product(product), .in_last(in_last), .out_valid(ov2), .out_ready(or2),
    .out_sum(s2), .out_count(c2), .out_overflow(of2), .out_forced(fo2)
  );

  logic   cur_valid, cur_in_ready, cur_ovf, cur_forced;
  longint cur_sum, cur_cnt;

  always_comb begin
    cur_valid = 1'b0; cur_in_ready = 1'b0; cur_ovf = 1'b0; cur_forced = 1'b0;
    cur_sum = 0; cur_cnt = 0;
    case (sel)
      0: begin
        cur_valid = ov0; cur_in_ready = ir0; cur_ovf = of0; cur_forced = fo0;
        cur_sum = longint'($signed(s0)); cur_cnt = longint'(c0);
      end
      1: begin
        cur_valid = ov1; cur_in_ready = ir1; cur_ovf = of1; cur_forced = fo1;
        cur_sum = longint'($signed(s1)); cur_cnt = longint'(c1);
      end
      default: begin
        cur_valid = ov2; cur_in_ready = ir2; cur_ovf = of2; cur_forced = fo2;
        cur_sum = longint'($signed(s2)); cur_cnt = longint'(c2);
      end
    endcase
  end

  // Clock and consumer-ready generation
  initial forever #5 clk = ~clk;

  always begin
    @(posedge clk);
    #2;
    out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_set;
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_acc[i] = 0; m_cnt[i] = 0; m_sticky[i] = 0;
    end
    exp_q.delete();
  endtask

  // Reference: unbounded sum clamped into the signed ACC_W range.
  task automatic model_accept(input logic [31:0] p, input bit last, input bit clr);
    longint hi, lo, s;
    hi = (longint'(1) <<< (m_w[sel] - 1)) - 1;
    lo = -hi - 1;
    if (clr) begin
      m_acc[sel] = 0; m_cnt[sel] = 0; m_sticky[sel] = 0;
    end
    s = m_acc[sel] + longint'($signed(p));
    if (s > hi) begin
      s = hi; m_sticky[sel] = 1;
    end else if (s < lo) begin
      s = lo; m_sticky[sel] = 1;
    end
    m_acc[sel] = s;
    m_cnt[sel]++;
    if (last || m_cnt[sel] == m_len[sel]) begin
      exp_q.push_back({2'(sel), 64'(s), 16'(m_cnt[sel]), m_sticky[sel], !last});
      m_acc[sel] = 0; m_cnt[sel] = 0; m_sticky[sel] = 0;
    end
  endtask

  // Driver: present one product, hold until accepted (bounded), then drop valid.
  task automatic send(input logic [31:0] p, input bit last, input bit clr);
    int waited = 0;
    in_valid = 1'b1; product = p; in_last = last; clear = clr;
    @(negedge clk);
    while (!cur_in_ready && waited < 300) begin
      waited++;
      @(negedge clk);
    end
    if (cur_in_ready)
      model_accept(p, last, clr);
    else begin
      checks++; errors++;
      $display("FAIL send_timeout actual=in_ready_low expected=accept_within_300");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0; clear = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual=%0d_pending expected=0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compares on every result transfer.
  task automatic monitor();
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && cur_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result actual=sum_%0d_count_%0d expected=no_result", cur_sum, cur_cnt);
        end else begin
          e = exp_q.pop_front();
          check("res_inst", longint'(sel), longint'(e[83:82]));
          check("res_sum", cur_sum, longint'($signed(e[81:18])));
          check("res_count", cur_cnt, longint'(e[17:2]));
          check("res_overflow", longint'(cur_ovf), longint'(e[1]));
          check("res_forced", longint'(cur_forced), longint'(e[0]));
        end
      end
    end
  endtask

  task automatic watchdog();
    #800000;
    checks++; errors++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  initial begin
    logic [31:0] p;
    int g;
    fork
      monitor();
      watchdog();
    join_none

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_valid", longint'(cur_valid), 0);
    check("rst_sum", cur_sum, 0);
    check("rst_count", cur_cnt, 0);
    check("rst_overflow", longint'(cur_ovf), 0);
    check("rst_forced", longint'(cur_forced), 0);
    check("rst_in_ready", longint'(cur_in_ready), 1);
    @(posedge clk);
    #1;

    // Basic dot product
    send(32'd100, 0, 0);
    send(32'hFFFF_FFE2, 0, 0);
    send(32'd7, 1, 0);
    @(negedge clk);
    check("t1_valid", longint'(cur_valid), 1);
    check("t1_sum", cur_sum, 77);
    check("t1_count", cur_cnt, 3);
    check("t1_forced", longint'(cur_forced), 0);
    @(posedge clk);
    #1;
    drain();

    // Backpressure hold, then back-to-back result
    rdy_set = 1'b0;
    send(32'd42, 1, 0);
    in_valid = 1'b1; product = 32'd9; in_last = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("hold_in_ready", longint'(cur_in_ready), 0);
      check("hold_valid", longint'(cur_valid), 1);
      check("hold_sum", cur_sum, 42);
      check("hold_count", cur_cnt, 1);
    end
    @(posedge clk);
    #1;
    rdy_set = 1'b1;
    send(32'd9, 1, 0);
    @(negedge clk);
    check("b2b_valid", longint'(cur_valid), 1);
    check("b2b_sum", cur_sum, 9);
    check("b2b_count", cur_cnt, 1);
    @(posedge clk);
    #1;
    drain();

    // Asynchronous reset mid-cycle discards the partial sum
    send(32'd5, 0, 0);
    send(32'd6, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", longint'(cur_valid), 0);
    check("arst_sum", cur_sum, 0);
    check("arst_count", cur_cnt, 0);
    check("arst_overflow", longint'(cur_ovf), 0);
    check("arst_forced", longint'(cur_forced), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(32'd5, 1, 0);
    drain();

    // clear together with a closing accept
    send(32'd10, 0, 0);
    send(32'd20, 0, 0);
    send(32'd3, 1, 1);
    drain();

    // Saturation on the 34-bit instance
    sel = 1;
    for (int i = 1; i <= 5; i++) send(32'h7FFF_FFFF, i == 5, 0);
    @(negedge clk);
    check("sat_hi_sum", cur_sum, 64'sd8589934591);
    check("sat_hi_overflow", longint'(cur_ovf), 1);
    @(posedge clk);
    #1;
    drain();
    for (int i = 1; i <= 5; i++) send(32'h8000_0000, i == 5, 0);
    @(negedge clk);
    check("sat_lo_sum", cur_sum, -64'sd8589934592);
    check("sat_lo_overflow", longint'(cur_ovf), 1);
    @(posedge clk);
    #1;
    drain();

    // Forced close on the MAX_LEN=4 instance
    sel = 2;
    for (int i = 1; i <= 8; i++) send(32'd1, i == 6, 0);
    drain();

    // Randomized traffic on each instance
    for (int k = 0; k < 3; k++) begin
      sel = (k == 0) ? 1 : (k == 1) ? 2 : 0;
      rdy_rand = 1'b1;
      repeat (250) begin
        case ($urandom_range(0, 3))
          0: p = 32'h7FFF_FFFF;
          1: p = 32'h8000_0000;
          default: p = $urandom();
        endcase
        send(p, $urandom_range(0, 5) == 0, $urandom_range(0, 19) == 0);
        g = $urandom_range(0, 3);
        if (g > 0) begin
          repeat (g) @(posedge clk);
          #1;
        end
      end
      send($urandom(), 1, 0);
      drain();
      rdy_rand = 1'b0;
      @(posedge clk);
      #1;
    end

    check("final_queue_empty", longint'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
